n64adv2_audio_gain_ramp: RTL

// - Parametrised N-channel audio gain stage for the APU output path. Sits between
//   the decimated FIR output and the I2S/SPDIF transmitters.
// - Generalises the fixed 2-channel amplifier:
//   - NUM_CH channels share one time-multiplexed multiplier.
//   - Data and gain widths are parameters.
//   - Gain ramps per frame to the target (click-free volume change and mute).
//   - Per-channel clip flags and dropped-frame reporting are added.
//

---
 rtl/n64adv2_audio_gain_ramp_pkg.sv | 22 ++
 rtl/n64adv2_sat_mult.sv | 65 ++++++
 rtl/n64adv2_audio_gain_ramp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/n64adv2_audio_gain_ramp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// n64adv2_audio_gain_ramp_pkg : shared APU audio gain constants and FSM states
// Revision 1.0
// ----------------------------------------------------------------------------
package n64adv2_audio_gain_ramp_pkg;

  localparam int APU_DEF_NUM_CH    = 2;
  localparam int APU_DEF_DATA_W    = 24;
  localparam int APU_DEF_GAIN_W    = 10;
  localparam int APU_DEF_GAIN_FRAC = 5;
  localparam int APU_UNITY_GAIN    = 1 << APU_DEF_GAIN_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULT     = 2'd1,
    ST_SAT_LAST = 2'd2,
    ST_DONE     = 2'd3
  } gain_state_e;

endpackage
`default_nettype wire

// File: rtl/n64adv2_sat_mult.sv
`default_nettype none
// ----------------------------------------------------------------------------
// n64adv2_sat_mult : registered signed x unsigned multiply, then shift/saturate
// Revision 1.0
// ----------------------------------------------------------------------------
module n64adv2_sat_mult
  import n64adv2_audio_gain_ramp_pkg::*;
#(
  parameter int DATA_W    = APU_DEF_DATA_W,
  parameter int GAIN_W    = APU_DEF_GAIN_W,
  parameter int GAIN_FRAC = APU_DEF_GAIN_FRAC
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic        [GAIN_W-1:0] gain_i,
  output logic                     vld_o,
  output logic signed [DATA_W-1:0] sat_o,
  output logic                     clip_o
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] C_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] C_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] a_w;
  logic signed [PROD_W-1:0] b_w;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] shift_w;
  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] prod_q;
  logic                     vld_q;

  // Gain is zero-extended so the DSP sees a signed x signed product.
  assign a_w     = {{(GAIN_W+1){sample_i[DATA_W-1]}}, sample_i};
  assign b_w     = {{(DATA_W+1){1'b0}}, gain_i};
  assign prod_d  = a_w * b_w;
  assign shift_w = prod_q >>> GAIN_FRAC;

  always_comb begin
    sat_o  = shift_w[DATA_W-1:0];
    clip_o = 1'b0;
    if (shift_w > C_MAX) begin
      sat_o  = C_MAX[DATA_W-1:0];
      clip_o = 1'b1;
    end else if (shift_w < C_MIN) begin
      sat_o  = C_MIN[DATA_W-1:0];
      clip_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) prod_q <= prod_d;
    end
  end

  assign vld_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/n64adv2_audio_gain_ramp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// n64adv2_audio_gain_ramp : N-channel audio gain stage with per-frame gain ramp
// Revision 1.0
// ----------------------------------------------------------------------------
module n64adv2_audio_gain_ramp
  import n64adv2_audio_gain_ramp_pkg::*;
#(
  parameter int NUM_CH    = APU_DEF_NUM_CH,
  parameter int DATA_W    = APU_DEF_DATA_W,
  parameter int GAIN_W    = APU_DEF_GAIN_W,
  parameter int GAIN_FRAC = APU_DEF_GAIN_FRAC,
  parameter int RAMP_STEP = 1
) (
  input  logic                     MCLK_i,
  input  logic                     nRST_i,
  input  logic [NUM_CH*DATA_W-1:0] PDATA_i,
  input  logic                     PDATA_VALID_i,
  input  logic [GAIN_W-1:0]        TGT_GAIN_i,
  input  logic                     MUTE_i,
  output logic [NUM_CH*DATA_W-1:0] PDATA_o,
  output logic                     PDATA_VALID_o,
  output logic [NUM_CH-1:0]        CLIP_o,
  output logic                     BUSY_o,
  output logic                     DROP_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   C_LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [GAIN_W:0]   C_STEP    = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [GAIN_W-1:0] C_STEP_G  = C_STEP[GAIN_W-1:0];

  gain_state_e state_q, state_d;
  logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]          res_ch_q;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic [NUM_CH*DATA_W-1:0] frame_q;
  logic [NUM_CH*DATA_W-1:0] stage_q, stage_d;
  logic [NUM_CH-1:0]        clip_stage_q, clip_stage_d;
  logic [NUM_CH*DATA_W-1:0] pdata_q;
  logic [NUM_CH-1:0]        clip_q;
  logic                     valid_q;
  logic                     drop_q;

  logic                     mul_en_w;
  logic                     mul_vld_w;
  logic signed [DATA_W-1:0] sample_w;
  logic signed [DATA_W-1:0] sat_w;
  logic                     clip_w;
  logic [GAIN_W-1:0]        eff_tgt_w;
  logic [GAIN_W-1:0]        diff_w;
  logic [GAIN_W-1:0]        gain_ramp_w;

  assign sample_w = frame_q[ch_cnt_q*DATA_W +: DATA_W];

  n64adv2_sat_mult #(
    .DATA_W   (DATA_W),
    .GAIN_W   (GAIN_W),
    .GAIN_FRAC(GAIN_FRAC)
  ) u_sat_mult (
    .clk_i   (MCLK_i),
    .rst_n_i (nRST_i),
    .en_i    (mul_en_w),
    .sample_i(sample_w),
    .gain_i  (gain_q),
    .vld_o   (mul_vld_w),
    .sat_o   (sat_w),
    .clip_o  (clip_w)
  );

  // Step toward the target without overshooting it; the difference is
  // compared first so the add/subtract can never wrap.
  always_comb begin
    eff_tgt_w   = MUTE_i ? '0 : TGT_GAIN_i;
    diff_w      = '0;
    gain_ramp_w = gain_q;
    if (gain_q < eff_tgt_w) begin
      diff_w      = eff_tgt_w - gain_q;
      gain_ramp_w = ({1'b0, diff_w} > C_STEP) ? gain_q + C_STEP_G : eff_tgt_w;
    end else if (gain_q > eff_tgt_w) begin
      diff_w      = gain_q - eff_tgt_w;
      gain_ramp_w = ({1'b0, diff_w} > C_STEP) ? gain_q - C_STEP_G : eff_tgt_w;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    gain_d   = gain_q;
    mul_en_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PDATA_VALID_i) begin
          state_d  = ST_MULT;
          ch_cnt_d = '0;
        end
      end
      ST_MULT: begin
        mul_en_w = 1'b1;
        if (ch_cnt_q == C_LAST_CH) state_d = ST_SAT_LAST;
        else                       ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
      ST_SAT_LAST: state_d = ST_DONE;
      ST_DONE: begin
        gain_d  = gain_ramp_w;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturated results land in a staging bank so PDATA_o only changes on commit.
  always_comb begin
    stage_d      = stage_q;
    clip_stage_d = clip_stage_q;
    if (mul_vld_w) begin
      stage_d[res_ch_q*DATA_W +: DATA_W] = sat_w;
      clip_stage_d[res_ch_q]             = clip_w;
    end
  end

  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_q      <= ST_IDLE;
      ch_cnt_q     <= '0;
      res_ch_q     <= '0;
      gain_q       <= '0;
      frame_q      <= '0;
      stage_q      <= '0;
      clip_stage_q <= '0;
      pdata_q      <= '0;
      clip_q       <= '0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      gain_q       <= gain_d;
      stage_q      <= stage_d;
      clip_stage_q <= clip_stage_d;
      valid_q      <= (state_q == ST_SAT_LAST);
      drop_q       <= PDATA_VALID_i && (state_q != ST_IDLE);
      if (mul_en_w) res_ch_q <= ch_cnt_q;
      if ((state_q == ST_IDLE) && PDATA_VALID_i) frame_q <= PDATA_i;
      if (state_q == ST_SAT_LAST) begin
        pdata_q <= stage_d;
        clip_q  <= clip_stage_d;
      end
    end
  end

  assign PDATA_o       = pdata_q;
  assign CLIP_o        = clip_q;
  assign PDATA_VALID_o = valid_q;
  assign BUSY_o        = (state_q != ST_IDLE);
  assign DROP_o        = drop_q;

endmodule
`default_nettype wire
